scan_mux_n: RTL and testbench

//   Parametrised time-multiplexed N:1 selector. Rotates through CH input channels of W bits,
//   one slot every TICK_DIV clocks, with a registered data output and a one-hot channel strobe.

---
 rtl/scan_mux_n_if.sv | 46 ++++
 rtl/scan_mux_n.sv | 107 ++++++++++
 tb/tb_scan_mux_n.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/scan_mux_n_if.sv
//------------------------------------------------------------------------------
// Module : scan_mux_n_if
// Brief  : Bus bundle for the rotating N:1 scan selector. Optional force
//          ports are present only when SCAN_MUX_FORCE_EN is defined.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface scan_mux_n_if #(
  parameter int CH = 4,
  parameter int W  = 4
);
  localparam int c_sel_w = (CH > 1) ? $clog2(CH) : 1;

  logic                en;
  logic [CH*W-1:0]     d_flat;
  logic [CH-1:0]       blank;
  logic [W-1:0]        dout;
  logic [CH-1:0]       sel_oh;
  logic [c_sel_w-1:0]  sel_idx;
  logic                slot_tick;
`ifdef SCAN_MUX_FORCE_EN
  logic                force_vld;
  logic [c_sel_w-1:0]  force_idx;

  modport master (
    output en, d_flat, blank, force_vld, force_idx,
    input  dout, sel_oh, sel_idx, slot_tick
  );
  modport slave (
    input  en, d_flat, blank, force_vld, force_idx,
    output dout, sel_oh, sel_idx, slot_tick
  );
`else
  modport master (
    output en, d_flat, blank,
    input  dout, sel_oh, sel_idx, slot_tick
  );
  modport slave (
    input  en, d_flat, blank,
    output dout, sel_oh, sel_idx, slot_tick
  );
`endif
endinterface

`default_nettype wire

// File: rtl/scan_mux_n.sv
//------------------------------------------------------------------------------
// Module : scan_mux_n
// Brief  : Time-multiplexed CH:1 selector, one slot every TICK_DIV enabled
//          clocks, with registered data, one-hot strobe and index outputs.
//          Define SCAN_MUX_FORCE_EN to add the force_vld/force_idx jump ports.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module scan_mux_n #(
  parameter int CH       = 4,
  parameter int W        = 4,
  parameter int TICK_DIV = 50000
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  scan_mux_n_if.slave bus
);
  localparam int c_sel_w = (CH > 1) ? $clog2(CH) : 1;
  localparam int c_pw    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [c_pw-1:0]    r_presc;
  logic [c_sel_w-1:0] r_idx;
  logic [W-1:0]       r_dout;
  logic [CH-1:0]      r_sel_oh;
  logic               r_slot_tick;

  logic [c_pw-1:0]    w_presc_nxt;
  logic [c_sel_w-1:0] w_idx_nxt;
  logic               w_tick_nxt;
  logic               w_tc;
  logic               w_wrap;
  logic               w_force;
  logic [W-1:0]       w_ch [CH];
  logic [W-1:0]       w_dout_nxt;
  logic [CH-1:0]      w_oh_nxt;

  genvar k;
  generate
    for (k = 0; k < CH; k++) begin : g_unpack
      assign w_ch[k] = bus.d_flat[k*W +: W];
    end
  endgenerate

  assign w_tc   = bus.en && (r_presc == c_pw'(TICK_DIV - 1));
  assign w_wrap = (r_idx == c_sel_w'(CH - 1));

`ifdef SCAN_MUX_FORCE_EN
  // Out-of-range requests are dropped so idx can never leave 0..CH-1.
  assign w_force = bus.force_vld &&
                   ({1'b0, bus.force_idx} < (c_sel_w + 1)'(CH));
`else
  assign w_force = 1'b0;
`endif

  always_comb begin
    w_presc_nxt = r_presc;
    w_idx_nxt   = r_idx;
    w_tick_nxt  = 1'b0;
    if (w_force) begin
`ifdef SCAN_MUX_FORCE_EN
      w_idx_nxt   = bus.force_idx;
`endif
      w_presc_nxt = '0;
    end else if (w_tc) begin
      w_presc_nxt = '0;
      w_idx_nxt   = w_wrap ? '0 : r_idx + 1'b1;
      w_tick_nxt  = 1'b1;
    end else if (bus.en) begin
      w_presc_nxt = r_presc + 1'b1;
    end
  end

  // Outputs derive from the next index so data, strobe and index never skew.
  always_comb begin
    w_dout_nxt = w_ch[w_idx_nxt];
    w_oh_nxt   = CH'(1) << w_idx_nxt;
    if (bus.blank[w_idx_nxt]) begin
      w_dout_nxt = '0;
      w_oh_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_dout      <= '0;
      r_sel_oh    <= '0;
      r_slot_tick <= 1'b0;
    end else begin
      r_presc     <= w_presc_nxt;
      r_idx       <= w_idx_nxt;
      r_dout      <= w_dout_nxt;
      r_sel_oh    <= w_oh_nxt;
      r_slot_tick <= w_tick_nxt;
    end
  end

  assign bus.dout      = r_dout;
  assign bus.sel_oh    = r_sel_oh;
  assign bus.sel_idx   = r_idx;
  assign bus.slot_tick = r_slot_tick;

endmodule

`default_nettype wire

// File: tb/tb_scan_mux_n.sv
//------------------------------------------------------------------------------
// Module : tb_scan_mux_n
// Brief  : Randomised bench for scan_mux_n (CH=4/TICK_DIV=3 and CH=3/TICK_DIV=1)
//          against a slot-level reference model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_scan_mux_n;
  localparam int CH  = 4;
  localparam int W   = 4;
  localparam int TD  = 3;
  localparam int CH2 = 3;
  localparam int TD2 = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scan_mux_n_if #(.CH(CH),  .W(W)) bus  ();
  scan_mux_n_if #(.CH(CH2), .W(W)) bus2 ();

  scan_mux_n #(.CH(CH),  .W(W), .TICK_DIV(TD))  dut_a (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  scan_mux_n #(.CH(CH2), .W(W), .TICK_DIV(TD2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  int vectors     = 0;
  int miscompares = 0;

  // reference model: current slot, enabled clocks spent in it, expected outputs
  int ma_idx, ma_cnt, ea_dout, ea_oh, ea_idx, ea_tick;
  int mb_idx, mb_cnt, eb_dout, eb_oh, eb_idx, eb_tick;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int chan(input logic [31:0] d, input int idx);
    return int'((d >> (idx * W)) & ((1 << W) - 1));
  endfunction

  task automatic model_clear();
    ma_idx = 0; ma_cnt = 0; ea_dout = 0; ea_oh = 0; ea_idx = 0; ea_tick = 0;
    mb_idx = 0; mb_cnt = 0; eb_dout = 0; eb_oh = 0; eb_idx = 0; eb_tick = 0;
  endtask

  task automatic check_outputs();
    check_val("a_dout", 32'(bus.dout),      32'(ea_dout));
    check_val("a_oh",   32'(bus.sel_oh),    32'(ea_oh));
    check_val("a_idx",  32'(bus.sel_idx),   32'(ea_idx));
    check_val("a_tick", 32'(bus.slot_tick), 32'(ea_tick));
    check_val("b_dout", 32'(bus2.dout),     32'(eb_dout));
    check_val("b_oh",   32'(bus2.sel_oh),   32'(eb_oh));
    check_val("b_idx",  32'(bus2.sel_idx),  32'(eb_idx));
    check_val("b_tick", 32'(bus2.slot_tick),32'(eb_tick));
    check_val("b_range", 32'(bus2.sel_idx < 2'(CH2)), 32'd1);
  endtask

  task automatic clk_step();
    bit fa, fb;
    @(posedge clk);
    fa = 1'b0;
    fb = 1'b0;
`ifdef SCAN_MUX_FORCE_EN
    fa = bus.force_vld  && (int'(bus.force_idx)  < CH);
    fb = bus2.force_vld && (int'(bus2.force_idx) < CH2);
`endif
    if (!rst_n) begin
      model_clear();
    end else begin
      ea_tick = 0;
      if (fa) begin
`ifdef SCAN_MUX_FORCE_EN
        ma_idx = int'(bus.force_idx);
`endif
        ma_cnt = 0;
      end else if (bus.en) begin
        ma_cnt++;
        if (ma_cnt == TD) begin
          ma_cnt  = 0;
          ma_idx  = (ma_idx + 1) % CH;
          ea_tick = 1;
        end
      end
      ea_idx  = ma_idx;
      ea_dout = bus.blank[ma_idx] ? 0 : chan(32'(bus.d_flat), ma_idx);
      ea_oh   = bus.blank[ma_idx] ? 0 : (1 << ma_idx);

      eb_tick = 0;
      if (fb) begin
`ifdef SCAN_MUX_FORCE_EN
        mb_idx = int'(bus2.force_idx);
`endif
        mb_cnt = 0;
      end else if (bus2.en) begin
        mb_cnt++;
        if (mb_cnt == TD2) begin
          mb_cnt  = 0;
          mb_idx  = (mb_idx + 1) % CH2;
          eb_tick = 1;
        end
      end
      eb_idx  = mb_idx;
      eb_dout = bus2.blank[mb_idx] ? 0 : chan(32'(bus2.d_flat), mb_idx);
      eb_oh   = bus2.blank[mb_idx] ? 0 : (1 << mb_idx);
    end
    #1;
    check_outputs();
  endtask

  // Asserts rst_n between edges, checks the immediate clear, holds one edge, releases.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs();
    clk_step();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    bus.en = 1'b1;  bus.d_flat = 16'h4321; bus.blank = '0;
    bus2.en = 1'b1; bus2.d_flat = 12'h321; bus2.blank = '0;
`ifdef SCAN_MUX_FORCE_EN
    bus.force_vld = 1'b0;  bus.force_idx = '0;
    bus2.force_vld = 1'b0; bus2.force_idx = '0;
`endif
    model_clear();
    clk_step();                  // reset state with rst_n held low
    #2 rst_n = 1'b1;

    // basic rotation 1,2,3,4,1
    for (int i = 0; i < 3; i++) clk_step();
    check_val("seq_dout_slot1", 32'(bus.dout),      32'd2);
    check_val("seq_oh_slot1",   32'(bus.sel_oh),    32'b0010);
    check_val("seq_tick_slot1", 32'(bus.slot_tick), 32'd1);
    for (int i = 0; i < 10; i++) clk_step();

    // blanked slot 2
    bus.blank = 4'b0100;
    for (int i = 0; i < 14; i++) clk_step();
    bus.blank = '0;

    // freeze during slot 1 and update channel 1 data
    for (int i = 0; i < 20 && bus.sel_idx != 2'd1; i++) clk_step();
    check_val("wait_slot1", 32'(bus.sel_idx), 32'd1);
    bus.en = 1'b0;
    clk_step();
    clk_step();
    bus.d_flat[7:4] = 4'h9;
    clk_step();
    check_val("freeze_dout", 32'(bus.dout),    32'h9);
    check_val("freeze_idx",  32'(bus.sel_idx), 32'd1);
    for (int i = 0; i < 7; i++) clk_step();
    check_val("freeze_hold", 32'(bus.sel_idx), 32'd1);
    bus.en = 1'b1;
    bus.d_flat = 16'h4321;

    // reset mid-slot 2
    for (int i = 0; i < 20 && bus.sel_idx != 2'd2; i++) clk_step();
    check_val("wait_slot2", 32'(bus.sel_idx), 32'd2);
    clk_step();
    async_reset();
    clk_step();
    clk_step();
    check_val("post_rst_dout", 32'(bus.dout),    32'd1);
    check_val("post_rst_idx",  32'(bus.sel_idx), 32'd0);
    clk_step();
    check_val("post_rst_adv",  32'(bus.sel_idx), 32'd1);

`ifdef SCAN_MUX_FORCE_EN
    // jump from slot 0 terminal count to slot 3; out-of-range request on CH=3 unit
    async_reset();
    clk_step();
    clk_step();
    bus.force_vld = 1'b1;  bus.force_idx = 2'd3;
    bus2.force_vld = 1'b1; bus2.force_idx = 2'd3;
    clk_step();
    check_val("force_idx",  32'(bus.sel_idx),   32'd3);
    check_val("force_tick", 32'(bus.slot_tick), 32'd0);
    bus.force_vld = 1'b0;
    bus2.force_vld = 1'b0;
    for (int i = 0; i < 4; i++) clk_step();
`endif

    // randomised traffic
    for (int i = 0; i < 600; i++) begin
      bus.en      = ($urandom_range(0, 7) != 0);
      bus2.en     = ($urandom_range(0, 5) != 0);
      bus.d_flat  = 16'($urandom());
      bus2.d_flat = 12'($urandom());
      bus.blank   = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : '0;
      bus2.blank  = ($urandom_range(0, 3) == 0) ? 3'($urandom()) : '0;
`ifdef SCAN_MUX_FORCE_EN
      bus.force_vld  = ($urandom_range(0, 15) == 0);
      bus.force_idx  = 2'($urandom());
      bus2.force_vld = ($urandom_range(0, 15) == 0);
      bus2.force_idx = 2'($urandom());
`endif
      if ($urandom_range(0, 99) == 0) async_reset();
      else clk_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
